// File: rtl/bitonic_pkg.sv
// Shared helpers for the bitonic sorting pipeline: network depth and the
// mapping from a flat layer index to its (stage, substage) position.
package bitonic_pkg;

  // Number of merge stages for an n-lane network.
  function automatic int STAGES(input int n);
    return $clog2(n);
  endfunction

  // Number of compare-exchange layers (one register layer each).
  function automatic int LAYERS(input int n);
    int s;
    s = $clog2(n);
    return (s * (s + 1)) / 2;
  endfunction

  // Stage s owns s+1 consecutive layers; walk them to find the stage.
  function automatic int layer_stage(input int idx);
    int rem;
    int s;
    rem = idx;
    s   = 0;
    for (int k = 0; k < 64; k++) begin
      if (rem > s) begin
        rem = rem - (s + 1);
        s   = s + 1;
      end
    end
    return s;
  endfunction

  // Substages count down from s to 0 inside a stage.
  function automatic int layer_sub(input int idx);
    int rem;
    int s;
    rem = idx;
    s   = 0;
    for (int k = 0; k < 64; k++) begin
      if (rem > s) begin
        rem = rem - (s + 1);
        s   = s + 1;
      end
    end
    return s - rem;
  endfunction

  // 1 = pair sorts descending before the per-vector mode is applied.
  // Lanes are below 2^S, so bit S reads as 0 on the final stage.
  function automatic logic pair_dir(input int stage, input int lane);
    return ((lane >> (stage + 1)) & 1) != 0;
  endfunction

endpackage

// File: rtl/bitonic_cmp_layer.sv
// One registered compare-exchange layer of the bitonic network.
// Optional macro BITONIC_SORT_INDEX_EN carries source-lane indices alongside keys.
module bitonic_cmp_layer
  import bitonic_pkg::*;
#(
  parameter int NUM_INPUT  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int STAGE      = 0,
  parameter int SUB        = 0
`ifdef BITONIC_SORT_INDEX_EN
  ,
  parameter int IDX_W      = 3
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            adv,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] data_i,
  input  logic                            descend_i,
  input  logic                            valid_i,
`ifdef BITONIC_SORT_INDEX_EN
  input  logic [NUM_INPUT*IDX_W-1:0]      index_i,
  output logic [NUM_INPUT*IDX_W-1:0]      index_o,
`endif
  output logic [NUM_INPUT*DATA_WIDTH-1:0] data_o,
  output logic                            descend_o,
  output logic                            valid_o
);

  logic [NUM_INPUT*DATA_WIDTH-1:0] data_d, data_q;
  logic                            descend_q, valid_q;
`ifdef BITONIC_SORT_INDEX_EN
  logic [NUM_INPUT*IDX_W-1:0]      index_d, index_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUT; gi++) begin : g_lane
      // The lower lane of each pair drives both lanes of the pair.
      if (((gi >> SUB) & 1) == 0) begin : g_pair
        localparam int   PARTNER = gi + (1 << SUB);
        localparam logic DIR     = pair_dir(STAGE, gi);
        logic [DATA_WIDTH-1:0] key_a, key_b;
        logic                  desc_pair, swap;
        assign key_a     = data_i[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH];
        assign key_b     = data_i[DATA_WIDTH*(PARTNER+1)-1 -: DATA_WIDTH];
        assign desc_pair = DIR ^ descend_i;
        // Strict comparison: equal keys stay where they are.
        assign swap      = desc_pair ? (key_a < key_b) : (key_a > key_b);
        assign data_d[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH]      = swap ? key_b : key_a;
        assign data_d[DATA_WIDTH*(PARTNER+1)-1 -: DATA_WIDTH] = swap ? key_a : key_b;
`ifdef BITONIC_SORT_INDEX_EN
        assign index_d[IDX_W*(gi+1)-1 -: IDX_W] =
          swap ? index_i[IDX_W*(PARTNER+1)-1 -: IDX_W] : index_i[IDX_W*(gi+1)-1 -: IDX_W];
        assign index_d[IDX_W*(PARTNER+1)-1 -: IDX_W] =
          swap ? index_i[IDX_W*(gi+1)-1 -: IDX_W] : index_i[IDX_W*(PARTNER+1)-1 -: IDX_W];
`endif
      end
    end
  endgenerate

  // Capture the exchanged vector whenever the whole pipeline advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      descend_q <= 1'b0;
      valid_q   <= 1'b0;
`ifdef BITONIC_SORT_INDEX_EN
      index_q   <= '0;
`endif
    end else if (adv) begin
      data_q    <= data_d;
      descend_q <= descend_i;
      valid_q   <= valid_i;
`ifdef BITONIC_SORT_INDEX_EN
      index_q   <= index_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign descend_o = descend_q;
  assign valid_o   = valid_q;
`ifdef BITONIC_SORT_INDEX_EN
  assign index_o   = index_q;
`endif

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter with valid/ready flow control; all layers
// stall together, bubbles are kept. Optional macro BITONIC_SORT_INDEX_EN
// adds out_index (source lane of each sorted key).
module bitonic_sort_pipe
  import bitonic_pkg::*;
#(
  parameter int NUM_INPUT  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] in_data,
  input  logic                            in_descend,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_INPUT*DATA_WIDTH-1:0] out_data,
  output logic                            out_descend,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef BITONIC_SORT_INDEX_EN
  output logic [NUM_INPUT*$clog2(NUM_INPUT)-1:0] out_index,
`endif
  output logic                            busy
);

  localparam int NUM_LAYERS = LAYERS(NUM_INPUT);
  localparam int VEC_W      = NUM_INPUT * DATA_WIDTH;

  logic [VEC_W-1:0] data_c  [NUM_LAYERS+1];
  logic             desc_c  [NUM_LAYERS+1];
  logic             valid_c [NUM_LAYERS+1];
  logic             adv;

`ifdef BITONIC_SORT_INDEX_EN
  localparam int IDX_W = $clog2(NUM_INPUT);
  logic [NUM_INPUT*IDX_W-1:0] index_c [NUM_LAYERS+1];
`endif

  // Output register frees up when empty or being drained this cycle.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign data_c[0]  = in_data;
  assign desc_c[0]  = in_descend;
  assign valid_c[0] = in_valid;

  genvar gi;
  generate
`ifdef BITONIC_SORT_INDEX_EN
    // Each lane starts out tagged with its own lane number.
    for (gi = 0; gi < NUM_INPUT; gi++) begin : g_idx_init
      assign index_c[0][IDX_W*(gi+1)-1 -: IDX_W] = IDX_W'(gi);
    end
`endif
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      bitonic_cmp_layer #(
        .NUM_INPUT  (NUM_INPUT),
        .DATA_WIDTH (DATA_WIDTH),
        .STAGE      (layer_stage(gi)),
        .SUB        (layer_sub(gi))
`ifdef BITONIC_SORT_INDEX_EN
        ,
        .IDX_W      (IDX_W)
`endif
      ) u_layer (
        .clk       (clk),
        .reset     (reset),
        .adv       (adv),
        .data_i    (data_c[gi]),
        .descend_i (desc_c[gi]),
        .valid_i   (valid_c[gi]),
`ifdef BITONIC_SORT_INDEX_EN
        .index_i   (index_c[gi]),
        .index_o   (index_c[gi+1]),
`endif
        .data_o    (data_c[gi+1]),
        .descend_o (desc_c[gi+1]),
        .valid_o   (valid_c[gi+1])
      );
    end
  endgenerate

  assign out_data    = data_c[NUM_LAYERS];
  assign out_descend = desc_c[NUM_LAYERS];
  assign out_valid   = valid_c[NUM_LAYERS];
`ifdef BITONIC_SORT_INDEX_EN
  assign out_index   = index_c[NUM_LAYERS];
`endif

  // Busy while any layer register holds a live vector.
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= NUM_LAYERS; k++) begin
      busy = busy | valid_c[k];
    end
  end

endmodule
